// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S 16-bit processor.
package k_and_s_pkg;

  // Instruction decode presented to the control unit by the IR decoder.
  // Codes 4'hE and 4'hF are unused and are treated like NOP by the sequencer.
  typedef enum logic [3:0] {
    I_NOP    = 4'h0,
    I_LOAD   = 4'h1,
    I_STORE  = 4'h2,
    I_MOVE   = 4'h3,
    I_ADD    = 4'h4,
    I_SUB    = 4'h5,
    I_AND    = 4'h6,
    I_OR     = 4'h7,
    I_BRANCH = 4'h8,
    I_BZERO  = 4'h9,
    I_BNZERO = 4'hA,
    I_BNEG   = 4'hB,
    I_BNNEG  = 4'hC,
    I_HALT   = 4'hD
  } decoded_instruction_type;

  // Control unit sequencer states.
  typedef enum logic [3:0] {
    S_FETCH      = 4'h0,
    S_FETCH_WAIT = 4'h1,
    S_DECODE     = 4'h2,
    S_LOAD_RD    = 4'h3,
    S_LOAD_WB    = 4'h4,
    S_STORE      = 4'h5,
    S_MOVE       = 4'h6,
    S_ALU        = 4'h7,
    S_BRANCH     = 4'h8,
    S_BCOND      = 4'h9,
    S_OVF_CHECK  = 4'hA,
    S_HALT       = 4'hB
  } ctrl_state_type;

  // ALU operation select codes.
  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  // Map an arithmetic/logic instruction onto its ALU operation code.
  function automatic logic [1:0] alu_op(input decoded_instruction_type instr);
    logic [1:0] op;
    op = ALU_OR;
    case (instr)
      I_ADD:   op = ALU_ADD;
      I_SUB:   op = ALU_SUB;
      I_AND:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute Moore sequencer for the K&S processor.
// Optional feature macro: K_AND_S_OVF_TRAP_EN (signed-overflow trap after ADD/SUB).
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    trap
);

  ctrl_state_type state_q, state_d;
  logic           cond_taken;

`ifdef K_AND_S_OVF_TRAP_EN
  logic trap_q, trap_d;
  logic unused_flags;
  assign unused_flags = unsigned_overflow;
`else
  logic unused_flags;
  assign unused_flags = unsigned_overflow ^ signed_overflow;
`endif

  // State register; reset forces FETCH immediately, aborting any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef K_AND_S_OVF_TRAP_EN
  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // Conditional-branch predicate from the registered flags.
  always_comb begin
    cond_taken = 1'b0;
    case (decoded_instruction)
      I_BZERO:  cond_taken = zero_op;
      I_BNZERO: cond_taken = ~zero_op;
      I_BNEG:   cond_taken = neg_op;
      I_BNNEG:  cond_taken = ~neg_op;
      default:  cond_taken = 1'b0;
    endcase
  end

  // Next-state and Moore outputs (branch strobes in BCOND gated by flags).
  always_comb begin
    state_d          = state_q;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b1;
    c_sel            = 1'b0;
    operation        = ALU_OR;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
`ifdef K_AND_S_OVF_TRAP_EN
    trap_d           = trap_q;
`endif

    case (state_q)
      S_FETCH: begin
        state_d = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        ir_enable = 1'b1;
        state_d   = S_DECODE;
      end

      S_DECODE: begin
        pc_enable = 1'b1;
        case (decoded_instruction)
          I_LOAD:   state_d = S_LOAD_RD;
          I_STORE:  state_d = S_STORE;
          I_MOVE:   state_d = S_MOVE;
          I_ADD,
          I_SUB,
          I_AND,
          I_OR:     state_d = S_ALU;
          I_BRANCH: state_d = S_BRANCH;
          I_BZERO,
          I_BNZERO,
          I_BNEG,
          I_BNNEG:  state_d = S_BCOND;
          I_HALT:   state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end

      S_LOAD_RD: begin
        addr_sel = 1'b0;
        state_d  = S_LOAD_WB;
      end

      S_LOAD_WB: begin
        addr_sel         = 1'b0;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end

      S_STORE: begin
        addr_sel         = 1'b0;
        ram_write_enable = 1'b1;
        state_d          = S_FETCH;
      end

      S_MOVE: begin
        operation        = ALU_OR;
        write_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end

      S_ALU: begin
        operation        = alu_op(decoded_instruction);
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        state_d          = S_FETCH;
`ifdef K_AND_S_OVF_TRAP_EN
        if (decoded_instruction == I_ADD || decoded_instruction == I_SUB) begin
          state_d = S_OVF_CHECK;
        end
`endif
      end

      S_BRANCH: begin
        branch    = 1'b1;
        pc_enable = 1'b1;
        state_d   = S_FETCH;
      end

      S_BCOND: begin
        branch    = cond_taken;
        pc_enable = cond_taken;
        state_d   = S_FETCH;
      end

      S_OVF_CHECK: begin
        state_d = S_FETCH;
`ifdef K_AND_S_OVF_TRAP_EN
        if (signed_overflow) begin
          trap_d  = 1'b1;
          state_d = S_HALT;
        end
`endif
      end

      S_HALT: begin
        halt    = 1'b1;
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: per-cycle expected output
// vectors are queued when an instruction is issued and compared each cycle.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic                    clk;
  logic                    rst;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic                    ram_write_enable;
  logic                    halt;
  logic                    trap;

  int unsigned errors;
  int unsigned checks;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  control_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt),
    .trap                (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {branch,pc_en,ir_en,addr_sel,c_sel,op[1:0],wr,fl,rw,halt,trap}
  function automatic logic [11:0] ov(input logic br, input logic pc, input logic ir,
                                     input logic as, input logic cs, input logic [1:0] op,
                                     input logic wr, input logic fl, input logic rw,
                                     input logic h, input logic t);
    return {br, pc, ir, as, cs, op, wr, fl, rw, h, t};
  endfunction

  function automatic logic [11:0] observed();
    return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
            write_reg_enable, flags_reg_enable, ram_write_enable, halt, trap};
  endfunction

  logic [11:0] V_IDLE, V_FW, V_DEC, V_LRD, V_LWB, V_ST, V_MV, V_BR, V_HALT;

  task automatic push(input logic [11:0] v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Compare the current DUT outputs against the oldest queued expectation.
  task automatic check_next();
    logic [11:0] e;
    logic [11:0] o;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", t, o, e);
    end
  endtask

  // Compare every queued expectation, one per clock (sampled on negedge).
  task automatic drain();
    while (exp_q.size() > 0) begin
      check_next();
      @(negedge clk);
    end
  endtask

  // Queue the expected per-cycle outputs for one instruction from FETCH.
  task automatic push_instr(input decoded_instruction_type ins, input logic z,
                            input logic n, input logic ovf);
    logic taken;
    push(V_IDLE, "fetch");
    push(V_FW,   "fetch_wait");
    push(V_DEC,  "decode");
    case (ins)
      I_LOAD:   begin push(V_LRD, "load_rd"); push(V_LWB, "load_wb"); end
      I_STORE:  push(V_ST, "store");
      I_MOVE:   push(V_MV, "move");
      I_ADD, I_SUB, I_AND, I_OR: begin
        logic [1:0] op;
        op = (ins == I_ADD) ? 2'b01 : (ins == I_SUB) ? 2'b10 :
             (ins == I_AND) ? 2'b11 : 2'b00;
        push(ov(0,0,0,1,0,op,1,1,0,0,0), "alu");
`ifdef K_AND_S_OVF_TRAP_EN
        if (ins == I_ADD || ins == I_SUB) begin
          push(V_IDLE, "ovf_check");
          if (ovf) begin
            for (int i = 0; i < 3; i++) push(ov(0,0,0,1,0,2'b00,0,0,0,1,1), "trap_halt");
          end
        end
`else
        if (ovf) taken = 1'b0;
`endif
      end
      I_BRANCH: push(V_BR, "branch");
      I_BZERO, I_BNZERO, I_BNEG, I_BNNEG: begin
        taken = (ins == I_BZERO)  ?  z :
                (ins == I_BNZERO) ? ~z :
                (ins == I_BNEG)   ?  n : ~n;
        push(ov(taken,taken,0,1,0,2'b00,0,0,0,0,0), "bcond");
      end
      I_HALT: begin
        for (int i = 0; i < 20; i++) push(V_HALT, "halt_hold");
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input decoded_instruction_type ins, input logic z,
                           input logic n, input logic ovf);
    decoded_instruction = ins;
    zero_op             = z;
    neg_op              = n;
    signed_overflow     = ovf;
    unsigned_overflow   = ovf;
    push_instr(ins, z, n, ovf);
    drain();
  endtask

  // Pulse reset mid-cycle and confirm the sequencer restarts at FETCH.
  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    push(V_IDLE, tag);
    check_next();
    @(negedge clk);
    push(V_IDLE, {tag, "_held"});
    check_next();
    rst = 1'b0;
  endtask

  initial begin
    V_IDLE = ov(0,0,0,1,0,2'b00,0,0,0,0,0);
    V_FW   = ov(0,0,1,1,0,2'b00,0,0,0,0,0);
    V_DEC  = ov(0,1,0,1,0,2'b00,0,0,0,0,0);
    V_LRD  = ov(0,0,0,0,0,2'b00,0,0,0,0,0);
    V_LWB  = ov(0,0,0,0,1,2'b00,1,0,0,0,0);
    V_ST   = ov(0,0,0,0,0,2'b00,0,0,1,0,0);
    V_MV   = ov(0,0,0,1,0,2'b00,1,0,0,0,0);
    V_BR   = ov(1,1,0,1,0,2'b00,0,0,0,0,0);
    V_HALT = ov(0,0,0,1,0,2'b00,0,0,0,1,0);

    errors = 0;
    checks = 0;
    rst = 1'b1;
    decoded_instruction = I_NOP;
    zero_op = 1'b0;
    neg_op = 1'b0;
    unsigned_overflow = 1'b0;
    signed_overflow = 1'b0;

    repeat (2) @(negedge clk);
    push(V_IDLE, "reset_state");
    check_next();
    rst = 1'b0;

    // Reset while in FETCH_WAIT aborts the fetch.
    decoded_instruction = I_STORE;
    push(V_IDLE, "pre_reset_fetch");
    check_next();
    @(negedge clk);
    push(V_FW, "pre_reset_fetch_wait");
    check_next();
    reset_pulse("reset_mid_fetch_wait");

    run_instr(I_NOP,    0, 0, 0);
    run_instr(I_LOAD,   0, 0, 0);
    run_instr(I_STORE,  0, 0, 0);
    run_instr(I_MOVE,   0, 0, 0);
    run_instr(I_SUB,    0, 0, 0);
    run_instr(I_AND,    0, 0, 0);
    run_instr(I_OR,     0, 0, 0);
    run_instr(I_BRANCH, 0, 0, 0);
    run_instr(I_BZERO,  1, 0, 0);
    run_instr(I_BZERO,  0, 0, 0);
    run_instr(I_BNZERO, 0, 1, 0);
    run_instr(I_BNZERO, 1, 0, 0);
    run_instr(I_BNEG,   0, 1, 0);
    run_instr(I_BNEG,   1, 0, 0);
    run_instr(I_BNNEG,  0, 0, 0);
    run_instr(I_BNNEG,  0, 1, 0);
    run_instr(decoded_instruction_type'(4'hF), 0, 0, 0);
    run_instr(I_ADD,    0, 0, 0);
    run_instr(I_LOAD,   1, 1, 0);

`ifdef K_AND_S_OVF_TRAP_EN
    run_instr(I_SUB,    0, 0, 0);
    run_instr(I_ADD,    0, 0, 1);
    reset_pulse("reset_after_trap");
`else
    // Without the trap feature an overflowing ADD simply completes.
    run_instr(I_ADD,    0, 0, 1);
`endif

    run_instr(I_HALT,   0, 0, 0);
    reset_pulse("reset_from_halt");
    run_instr(I_MOVE,   0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
